// File: rtl/uart_tx_buffer.sv
// Transmit byte FIFO plus launch sequencer: queues host bytes and hands them to the
// uart core one at a time, waiting for each transfer to complete before the next.
module uart_tx_buffer #(
   parameter int unsigned DEPTH_BITS   = 4,
   parameter int unsigned ALMOST_FULL  = 12,
   parameter int unsigned BUSY_TIMEOUT = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_stb,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count,
   output logic                  overflow,
   output logic                  launch_error,
   input  logic                  clear_status,
   output logic                  idle,
   output logic                  uart_transmit,
   output logic [7:0]            uart_tx_byte,
   input  logic                  uart_is_transmitting
);

   localparam int unsigned PTR_W = DEPTH_BITS;
   localparam int unsigned CNT_W = DEPTH_BITS + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_BITS;
   localparam int unsigned TMO_W = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CNT_W-1:0]   count_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic [7:0]         tx_byte_nxt;
   logic               push, pop, ovf_evt, tmo_evt;
   logic               full_nxt, almost_full_nxt, empty_nxt, idle_nxt;
   logic               overflow_nxt, launch_error_nxt, uart_transmit_nxt;

   // Launch sequencer; a pop happens on the IDLE->LAUNCH transition
   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      pop         = 1'b0;
      tmo_evt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !uart_is_transmitting) begin
               pop       = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            tmo_cnt_nxt = '0;
            state_nxt   = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (uart_is_transmitting) begin
               state_nxt = WAIT_DONE;
            end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT)) begin
               tmo_evt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!uart_is_transmitting) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         pop       = 1'b0;
      end
   end

   // FIFO bookkeeping and next values of the registered status outputs
   always_comb begin
      push        = wr_stb && !full && !flush;
      ovf_evt     = wr_stb && full && !flush;
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      count_nxt   = count;
      tx_byte_nxt = uart_tx_byte;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr_nxt  = rd_ptr + PTR_W'(1);
            tx_byte_nxt = mem[rd_ptr];
         end
         count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      end
      full_nxt          = (count_nxt == CNT_W'(DEPTH));
      almost_full_nxt   = (count_nxt >= CNT_W'(ALMOST_FULL));
      empty_nxt         = (count_nxt == '0);
      idle_nxt          = empty_nxt && (state_nxt == IDLE);
      uart_transmit_nxt = (state_nxt == LAUNCH);
      // a new error event in the clear cycle wins over the clear
      overflow_nxt      = (overflow && !clear_status) || ovf_evt;
      launch_error_nxt  = (launch_error && !clear_status) || tmo_evt;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         tmo_cnt       <= '0;
         full          <= 1'b0;
         almost_full   <= 1'b0;
         empty         <= 1'b1;
         idle          <= 1'b1;
         overflow      <= 1'b0;
         launch_error  <= 1'b0;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= '0;
      end else begin
         state         <= state_nxt;
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         count         <= count_nxt;
         tmo_cnt       <= tmo_cnt_nxt;
         full          <= full_nxt;
         almost_full   <= almost_full_nxt;
         empty         <= empty_nxt;
         idle          <= idle_nxt;
         overflow      <= overflow_nxt;
         launch_error  <= launch_error_nxt;
         uart_transmit <= uart_transmit_nxt;
         uart_tx_byte  <= tx_byte_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed and randomized bench for uart_tx_buffer; a queue-based reference model plus
// a simple uart core model check every cycle.
module tb_uart_tx_buffer;

   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int RESP  = 0;
   localparam int HOLD  = 1;
   localparam int DEAD  = 2;

   logic       clk = 1'b0;
   logic       rst, flush, wr_stb, clear_status, uart_is_transmitting;
   logic [7:0] wr_data;
   logic       full, almost_full, empty, overflow, launch_error, idle, uart_transmit;
   logic [4:0] count;
   logic [7:0] uart_tx_byte;

   uart_tx_buffer dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_stb(wr_stb), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .empty(empty), .count(count),
      .overflow(overflow), .launch_error(launch_error), .clear_status(clear_status),
      .idle(idle), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
      .uart_is_transmitting(uart_is_transmitting)
   );

   always #5 clk = ~clk;

   byte unsigned mq[$];
   byte unsigned launched[$];
   byte unsigned exp_q[$];
   logic m_ovf, m_lerr;
   int   since_launch, stall;
   int   mode, busy_len, busy_left;
   bit   pend;
   int   n_cmp, n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: capture inputs, advance, then update model, compare, and run the uart model
   task automatic step();
      logic w, f, c, r, b, lerr_evt;
      logic [7:0] d;
      bit was_full;
      w = wr_stb; d = wr_data; f = flush; c = clear_status; r = rst; b = uart_is_transmitting;
      was_full = (mq.size() == DEPTH);
      @(posedge clk); #1;
      lerr_evt = 1'b0;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0; m_lerr = 1'b0; since_launch = -1; stall = 0;
      end else begin
         if (since_launch >= 0) begin
            since_launch++;
            if (since_launch >= 2 && b) since_launch = -1;
            else if (since_launch == 9) begin lerr_evt = 1'b1; since_launch = -1; end
         end
         if (f) begin
            mq.delete();
            since_launch = -1;
         end else begin
            if (uart_transmit) begin
               chk("launch_while_busy", uart_is_transmitting, 1'b0);
               chk("launch_has_data", 32'(mq.size() != 0), 1);
               if (mq.size() != 0) begin
                  chk("tx_byte", uart_tx_byte, mq[0]);
                  launched.push_back(mq.pop_front());
               end
               since_launch = 0;
            end
            if (w && !was_full) mq.push_back(d);
         end
         m_ovf  = (m_ovf && !c) || (w && was_full && !f);
         m_lerr = (m_lerr && !c) || lerr_evt;
      end
      chk("count", count, 32'(mq.size()));
      chk("full", full, 32'(mq.size() == DEPTH));
      chk("empty", empty, 32'(mq.size() == 0));
      chk("almost_full", almost_full, 32'(mq.size() >= AF));
      chk("overflow", overflow, m_ovf);
      chk("launch_error", launch_error, m_lerr);
      chk("idle_implies_empty", idle & ~empty, 1'b0);
      if (!r && mq.size() != 0 && !uart_transmit && !uart_is_transmitting && since_launch < 0)
         stall++;
      else
         stall = 0;
      if (stall > 4) begin
         chk("launch_stall", 32'(stall), 4);
         stall = 0;
      end
      // uart core model: busy from the cycle after the launch pulse for busy_len cycles
      if (r || mode == HOLD) begin
         pend = 1'b0; busy_left = 0;
         uart_is_transmitting = (mode == HOLD);
      end else begin
         if (pend) begin
            pend = 1'b0; uart_is_transmitting = 1'b1; busy_left = busy_len;
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) uart_is_transmitting = 1'b0;
         end
         if (uart_transmit && mode == RESP) pend = 1'b1;
      end
   endtask

   task automatic write_byte(input logic [7:0] v);
      wr_stb = 1'b1; wr_data = v;
      step();
      wr_stb = 1'b0;
   endtask

   task automatic set_mode(input int m);
      mode = m; pend = 1'b0; busy_left = 0;
      uart_is_transmitting = (m == HOLD);
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while (!(mq.size() == 0 && !uart_is_transmitting && !pend && idle) && k < budget) begin
         step();
         k++;
      end
      chk(tag, 32'(k < budget), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, guard, maxc, base;
      n_cmp = 0; n_err = 0;
      m_ovf = 1'b0; m_lerr = 1'b0; since_launch = -1; stall = 0;
      mode = RESP; busy_len = 5; busy_left = 0; pend = 1'b0;
      rst = 1'b1; flush = 1'b0; wr_stb = 1'b0; wr_data = '0; clear_status = 1'b0;
      uart_is_transmitting = 1'b0;

      // reset
      repeat (3) step();
      rst = 1'b0;
      chk("rst_tx_byte", uart_tx_byte, 8'h00);
      chk("rst_transmit", uart_transmit, 1'b0);
      chk("rst_idle", idle, 1'b1);
      repeat (5) step();

      // single byte: count at N+1, launch pulse at N+2
      write_byte(8'hA5);
      chk("single_count", count, 1);
      chk("single_no_launch_yet", uart_transmit, 1'b0);
      step();
      chk("single_launch", uart_transmit, 1'b1);
      chk("single_byte", uart_tx_byte, 8'hA5);
      step();
      chk("single_pulse_width", uart_transmit, 1'b0);
      drain("single_drain", 100);
      chk("single_idle", idle, 1'b1);

      // fill with uart held busy; 17th byte is dropped
      set_mode(HOLD);
      step();
      launched.delete();
      for (int i = 0; i < 17; i++) begin
         write_byte(8'(i));
         if (i == 10) chk("fill_af_below", almost_full, 1'b0);
         if (i == 11) chk("fill_af_at", almost_full, 1'b1);
      end
      chk("fill_count", count, 16);
      chk("fill_full", full, 1'b1);
      chk("fill_overflow", overflow, 1'b1);
      set_mode(RESP);
      busy_len = 3;
      drain("fill_drain", 600);
      chk("fill_n_sent", 32'(launched.size()), 16);
      for (int i = 0; i < 16 && i < launched.size(); i++) chk("fill_order", launched[i], 32'(i));
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      chk("fill_ovf_cleared", overflow, 1'b0);

      // wrap: 40 random bytes against a 20-cycle uart
      busy_len = 20; launched.delete(); exp_q.delete();
      n = 0; guard = 0; maxc = 0;
      while (n < 40 && guard < 4000) begin
         if (mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
            wr_stb = 1'b1; wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            n++;
         end
         step();
         wr_stb = 1'b0;
         guard++;
         if (int'(count) > maxc) maxc = int'(count);
      end
      drain("wrap_drain", 2000);
      chk("wrap_max_count", 32'(maxc <= DEPTH), 1);
      chk("wrap_n_sent", 32'(launched.size()), 40);
      for (int i = 0; i < 40 && i < launched.size(); i++) chk("wrap_order", launched[i], exp_q[i]);

      // timeout: uart never goes busy
      set_mode(DEAD);
      step();
      write_byte(8'($urandom));
      write_byte(8'($urandom));
      chk("to_launch", uart_transmit, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 8) chk("to_err_early", launch_error, 1'b0);
         if (k == 9) chk("to_err_set", launch_error, 1'b1);
      end
      step();
      chk("to_next_launch", uart_transmit, 1'b1);
      repeat (12) step();

      // flush mid-stream with launch_error still set
      set_mode(RESP);
      busy_len = 20;
      step();
      for (int i = 0; i < 6; i++) write_byte(8'($urandom));
      chk("flush_pre_count", count, 5);
      flush = 1'b1; wr_stb = 1'b1; wr_data = 8'h5A;
      step();
      flush = 1'b0; wr_stb = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_transmit", uart_transmit, 1'b0);
      chk("flush_no_ovf", overflow, 1'b0);
      chk("flush_keeps_lerr", launch_error, 1'b1);
      base = launched.size();
      repeat (25) step();
      chk("flush_no_launch", 32'(launched.size()), 32'(base));
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      chk("clear_lerr", launch_error, 1'b0);

      // simultaneous write and pop at count 3
      drain("sim_pre_drain", 200);
      set_mode(HOLD);
      step();
      launched.delete(); exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'($urandom);
         exp_q.push_back(wr_data);
         write_byte(wr_data);
      end
      chk("sim_count_pre", count, 3);
      set_mode(RESP);
      busy_len = 4;
      wr_stb = 1'b1; wr_data = 8'($urandom);
      exp_q.push_back(wr_data);
      step();
      wr_stb = 1'b0;
      chk("sim_count_hold", count, 3);
      chk("sim_launch", uart_transmit, 1'b1);
      drain("sim_drain", 300);
      chk("sim_n_sent", 32'(launched.size()), 4);
      for (int i = 0; i < 4 && i < launched.size(); i++) chk("sim_order", launched[i], exp_q[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
